// File: rtl/cr_axis_chk_pkg.sv
// cr_axis_chk_pkg: shared tuser codes, frame-type bytes and frame-state type
// for the AXI-stream checker and its sub-modules.
package cr_axis_chk_pkg;

    // tuser[1:0] beat position codes
    localparam logic [1:0] TUSER_SOT = 2'b01;
    localparam logic [1:0] TUSER_EOT = 2'b10;
    localparam logic [1:0] TUSER_MID = 2'b11;

    // Frame-type byte carried in tdata[7:0] of the SoT beat
    localparam logic [7:0] FTYPE_CQE   = 8'h09;
    localparam logic [7:0] FTYPE_STATS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CQE   = 2'd2,
        ST_STATS = 2'd3
    } frame_state_e;

    // Frame type implied by the first data byte of a SoT beat
    function automatic frame_state_e classify_frame(input logic [7:0] type_byte);
        if (type_byte == FTYPE_CQE) begin
            return ST_CQE;
        end else if (type_byte == FTYPE_STATS) begin
            return ST_STATS;
        end
        return ST_DATA;
    endfunction

endpackage

// File: rtl/cr_axis_chk_fifo.sv
// cr_axis_chk_fifo: synchronous FIFO holding expected beats. The head word is
// read combinationally because the checker compares against it in the same
// cycle the monitored beat is observed.
module cr_axis_chk_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array, written on accepted push only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cr_axis_stream_checker.sv
// cr_axis_stream_checker: scoreboard for one AXI-stream tap. Expected beats
// are queued, each observed beat is compared against the queue head; errors,
// first-mismatch capture and an idle watchdog are reported on registered
// outputs. Optional build macro CR_AXIS_CHK_TID_EN adds tid as a compared field.
module cr_axis_stream_checker
    import cr_axis_chk_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int USER_W     = 8,
    parameter int TID_W      = 1,
    parameter int DEPTH      = 16,
    parameter int WDOG_LIMIT = 10000,
    parameter int CNT_W      = 16,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exp_tvalid,
    output logic              exp_tready,
    input  logic [DATA_W-1:0] exp_tdata,
    input  logic [USER_W-1:0] exp_tuser,
    input  logic [STRB_W-1:0] exp_tstrb,
    input  logic [TID_W-1:0]  exp_tid,
    input  logic              act_tvalid,
    input  logic              act_tready,
    input  logic [DATA_W-1:0] act_tdata,
    input  logic [USER_W-1:0] act_tuser,
    input  logic [STRB_W-1:0] act_tstrb,
    input  logic              act_tlast,
    input  logic [TID_W-1:0]  act_tid,
    input  logic              clr_errors,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_no_exp,
    output logic              wdog_expired,
    output logic              mm_valid,
    output logic [DATA_W-1:0] mm_act_data,
    output logic [DATA_W-1:0] mm_exp_data,
    output logic [31:0]       mm_beat
);
`ifdef CR_AXIS_CHK_TID_EN
    localparam int FIFO_W = DATA_W + USER_W + STRB_W + TID_W;
`else
    localparam int FIFO_W = DATA_W + USER_W + STRB_W;
`endif
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [FIFO_W-1:0]      push_word;
    logic [FIFO_W-1:0]      head_word;
    logic [DATA_W-1:0]      head_data;
    logic [USER_W-1:0]      head_user;
    logic [STRB_W-1:0]      head_strb;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] unused_fifo_count;
    logic                   act_beat;
    logic                   pop;
    logic                   no_exp;
    logic                   wdog_fire;

    frame_state_e           state_q, state_d, cur_state;
    logic                   is_sot, is_eot, exp_last, data_masked;
    logic                   data_mm, user_mm, strb_mm, last_mm, any_mm;
    logic [2:0]             beat_errs;
    logic [2:0]             err_inc;
    logic [CNT_W:0]         err_sum;
    logic [CNT_W-1:0]       err_count_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic [31:0]            beat_cnt_q;

`ifdef CR_AXIS_CHK_TID_EN
    logic [TID_W-1:0]       head_tid;
    logic                   tid_mm;
    assign push_word = {exp_tid, exp_tuser, exp_tstrb, exp_tdata};
    assign {head_tid, head_user, head_strb, head_data} = head_word;
    assign tid_mm    = pop && (head_tid != act_tid);
`else
    logic                   unused_tid;
    assign push_word  = {exp_tuser, exp_tstrb, exp_tdata};
    assign {head_user, head_strb, head_data} = head_word;
    assign unused_tid = ^{exp_tid, act_tid};
`endif

    assign exp_tready = !fifo_full;
    assign act_beat   = act_tvalid && act_tready;
    assign pop        = act_beat && !fifo_empty;
    assign no_exp     = act_beat && fifo_empty;

    cr_axis_chk_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (exp_tvalid && exp_tready),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // Frame tracking on the expected head and per-field compare of the current beat
    always_comb begin
        is_sot    = (head_user[1:0] == TUSER_SOT);
        is_eot    = (head_user[1:0] == TUSER_EOT);
        cur_state = state_q;
        if (state_q == ST_IDLE && is_sot) begin
            cur_state = classify_frame(head_data[7:0]);
        end
        state_d = state_q;
        if (pop) begin
            state_d = is_eot ? ST_IDLE : cur_state;
        end
        exp_last    = (cur_state == ST_CQE) && is_eot;
        data_masked = (cur_state == ST_STATS) && is_eot;
        data_mm     = pop && !data_masked && (head_data != act_tdata);
        user_mm     = pop && (head_user != act_tuser);
        strb_mm     = pop && (head_strb != act_tstrb);
        last_mm     = pop && (exp_last != act_tlast);
`ifdef CR_AXIS_CHK_TID_EN
        any_mm    = data_mm || user_mm || strb_mm || last_mm || tid_mm;
        beat_errs = 3'(data_mm) + 3'(user_mm) + 3'(strb_mm) + 3'(last_mm) + 3'(tid_mm);
`else
        any_mm    = data_mm || user_mm || strb_mm || last_mm;
        beat_errs = 3'(data_mm) + 3'(user_mm) + 3'(strb_mm) + 3'(last_mm);
`endif
    end

    // Watchdog: idle cycles with beats pending; fires once on reaching the limit
    always_comb begin
        wdog_fire = !act_beat && !fifo_empty && (wdog_q == WD_W'(WDOG_LIMIT - 1));
        wdog_d    = wdog_q;
        if (clr_errors || act_beat || fifo_empty) begin
            wdog_d = '0;
        end else if (wdog_q != WD_W'(WDOG_LIMIT)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // Saturating error accumulation of all error sources this cycle
    always_comb begin
        err_inc     = beat_errs + 3'(no_exp) + 3'(wdog_fire);
        err_sum     = {1'b0, err_count} + (CNT_W+1)'(err_inc);
        err_count_d = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    // Frame state, beat index and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            wdog_q     <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (act_beat) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
        end
    end

    // Error reporting; clear wins over any error raised in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count    <= '0;
            err_no_exp   <= 1'b0;
            wdog_expired <= 1'b0;
            mm_valid     <= 1'b0;
            mm_act_data  <= '0;
            mm_exp_data  <= '0;
            mm_beat      <= '0;
        end else if (clr_errors) begin
            err_count    <= '0;
            err_no_exp   <= 1'b0;
            wdog_expired <= 1'b0;
            mm_valid     <= 1'b0;
            mm_act_data  <= '0;
            mm_exp_data  <= '0;
            mm_beat      <= '0;
        end else begin
            err_count <= err_count_d;
            if (no_exp) begin
                err_no_exp <= 1'b1;
            end
            if (wdog_fire) begin
                wdog_expired <= 1'b1;
            end
            if (any_mm && !mm_valid) begin
                mm_valid    <= 1'b1;
                mm_act_data <= act_tdata;
                mm_exp_data <= head_data;
                mm_beat     <= beat_cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_cr_axis_stream_checker.sv
// tb_cr_axis_stream_checker: scoreboard bench. Expected beats are queued as
// they are pushed into the DUT; each monitored beat pops the queue, a small
// reference model predicts the error outputs, and they are compared one
// cycle later.
module tb_cr_axis_stream_checker;
    localparam int DATA_W = 64;
    localparam int USER_W = 8;
    localparam int STRB_W = 8;
    localparam int TID_W  = 1;
    localparam int DEPTH  = 16;
    localparam int WDOG   = 100;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              exp_tvalid = 1'b0;
    logic              exp_tready;
    logic [DATA_W-1:0] exp_tdata = '0;
    logic [USER_W-1:0] exp_tuser = '0;
    logic [STRB_W-1:0] exp_tstrb = '0;
    logic [TID_W-1:0]  exp_tid = '0;
    logic              act_tvalid = 1'b0;
    logic              act_tready = 1'b1;
    logic [DATA_W-1:0] act_tdata = '0;
    logic [USER_W-1:0] act_tuser = '0;
    logic [STRB_W-1:0] act_tstrb = '0;
    logic              act_tlast = 1'b0;
    logic [TID_W-1:0]  act_tid = '0;
    logic              clr_errors = 1'b0;
    logic [CNT_W-1:0]  err_count;
    logic              err_no_exp;
    logic              wdog_expired;
    logic              mm_valid;
    logic [DATA_W-1:0] mm_act_data;
    logic [DATA_W-1:0] mm_exp_data;
    logic [31:0]       mm_beat;

    cr_axis_stream_checker #(
        .DATA_W     (DATA_W),
        .USER_W     (USER_W),
        .TID_W      (TID_W),
        .DEPTH      (DEPTH),
        .WDOG_LIMIT (WDOG),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_tvalid   (exp_tvalid),
        .exp_tready   (exp_tready),
        .exp_tdata    (exp_tdata),
        .exp_tuser    (exp_tuser),
        .exp_tstrb    (exp_tstrb),
        .exp_tid      (exp_tid),
        .act_tvalid   (act_tvalid),
        .act_tready   (act_tready),
        .act_tdata    (act_tdata),
        .act_tuser    (act_tuser),
        .act_tstrb    (act_tstrb),
        .act_tlast    (act_tlast),
        .act_tid      (act_tid),
        .clr_errors   (clr_errors),
        .err_count    (err_count),
        .err_no_exp   (err_no_exp),
        .wdog_expired (wdog_expired),
        .mm_valid     (mm_valid),
        .mm_act_data  (mm_act_data),
        .mm_exp_data  (mm_exp_data),
        .mm_beat      (mm_beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  u;
        logic [7:0]  s;
    } beat_t;

    beat_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    // reference model state
    int          m_state;   // 0 idle, 1 data, 2 cqe, 3 stats
    int          m_err;
    bit          m_no_exp;
    bit          m_wdog;
    bit          m_mm_valid;
    logic [31:0] m_mm_beat;
    logic [63:0] m_mm_act;
    logic [63:0] m_mm_exp;
    logic [31:0] m_beat;

    task automatic check_val(input string tag, input logic [63:0] actv, input logic [63:0] expv);
        n_checks++;
        if (actv !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actv, expv);
        end
    endtask

    task automatic model_clear();
        m_err      = 0;
        m_no_exp   = 0;
        m_wdog     = 0;
        m_mm_valid = 0;
        m_mm_beat  = '0;
        m_mm_act   = '0;
        m_mm_exp   = '0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".err_count"},   64'(err_count),    64'(m_err));
        check_val({tag, ".err_no_exp"},  64'(err_no_exp),   64'(m_no_exp));
        check_val({tag, ".wdog"},        64'(wdog_expired), 64'(m_wdog));
        check_val({tag, ".mm_valid"},    64'(mm_valid),     64'(m_mm_valid));
        check_val({tag, ".mm_beat"},     64'(mm_beat),      64'(m_mm_beat));
        check_val({tag, ".mm_act_data"}, mm_act_data,       m_mm_act);
        check_val({tag, ".mm_exp_data"}, mm_exp_data,       m_mm_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        exp_tvalid = 1'b0;
        act_tvalid = 1'b0;
        clr_errors = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        m_state = 0;
        m_beat  = '0;
        model_clear();
        $display("reset");
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [7:0] u, input logic [7:0] s);
        bit accepted;
        @(negedge clk);
        exp_tvalid = 1'b1;
        exp_tdata  = d;
        exp_tuser  = u;
        exp_tstrb  = s;
        check_val("exp_tready", 64'(exp_tready), 64'(sb_q.size() < DEPTH));
        accepted = (sb_q.size() < DEPTH);
        if (accepted) sb_q.push_back('{d: d, u: u, s: s});
        @(posedge clk);
        #1;
        exp_tvalid = 1'b0;
        $display("push  d=%h u=%h s=%h accepted=%0d", d, u, s, accepted);
    endtask

    task automatic act_beat(input string tag, input logic [63:0] d, input logic [7:0] u,
                            input logic [7:0] s, input logic l, input logic clr);
        beat_t e;
        int    inc;
        int    cur;
        bit    eot, exp_l, mask, mm;
        @(negedge clk);
        act_tvalid = 1'b1;
        act_tdata  = d;
        act_tuser  = u;
        act_tstrb  = s;
        act_tlast  = l;
        clr_errors = clr;
        inc = 0;
        mm  = 0;
        if (sb_q.size() == 0) begin
            inc = 1;
            if (!clr) m_no_exp = 1;
        end else begin
            e   = sb_q.pop_front();
            cur = m_state;
            if (m_state == 0 && e.u[1:0] == 2'b01)
                cur = (e.d[7:0] == 8'h09) ? 2 : ((e.d[7:0] == 8'h08) ? 3 : 1);
            eot   = (e.u[1:0] == 2'b10);
            exp_l = (cur == 2) && eot;
            mask  = (cur == 3) && eot;
            if (!mask && e.d != d) inc++;
            if (e.u != u) inc++;
            if (e.s != s) inc++;
            if (exp_l != l) inc++;
            mm = (inc != 0);
            m_state = eot ? 0 : cur;
            if (mm && !m_mm_valid && !clr) begin
                m_mm_valid = 1;
                m_mm_beat  = m_beat;
                m_mm_act   = d;
                m_mm_exp   = e.d;
            end
        end
        if (clr) model_clear();
        else m_err = (m_err + inc > 65535) ? 65535 : m_err + inc;
        m_beat = m_beat + 32'd1;
        @(posedge clk);
        #1;
        act_tvalid = 1'b0;
        clr_errors = 1'b0;
        $display("beat  %s d=%h u=%h s=%h l=%0d clr=%0d err_count=%0d", tag, d, u, s, l, clr, err_count);
        check_outputs(tag);
    endtask

    initial begin
        do_reset();
        @(posedge clk);
        #1;
        check_val("rst.exp_tready", 64'(exp_tready), 64'd1);
        check_outputs("rst");

        // CQE frame, actual identical with tlast on EoT
        push_exp(64'h1122_3344_5566_7709, 8'h01, 8'hFF);
        push_exp(64'hA5A5_0000_1234_5678, 8'h03, 8'hFF);
        push_exp(64'h0000_0000_CAFE_F00D, 8'h02, 8'h0F);
        act_beat("cqe0", 64'h1122_3344_5566_7709, 8'h01, 8'hFF, 1'b0, 1'b0);
        act_beat("cqe1", 64'hA5A5_0000_1234_5678, 8'h03, 8'hFF, 1'b0, 1'b0);
        act_beat("cqe2", 64'h0000_0000_CAFE_F00D, 8'h02, 8'h0F, 1'b1, 1'b0);

        // Same CQE frame with missing tlast, then a later data mismatch
        do_reset();
        push_exp(64'h1122_3344_5566_7709, 8'h01, 8'hFF);
        push_exp(64'hA5A5_0000_1234_5678, 8'h03, 8'hFF);
        push_exp(64'h0000_0000_CAFE_F00D, 8'h02, 8'h0F);
        act_beat("cqe_nl0", 64'h1122_3344_5566_7709, 8'h01, 8'hFF, 1'b0, 1'b0);
        act_beat("cqe_nl1", 64'hA5A5_0000_1234_5678, 8'h03, 8'hFF, 1'b0, 1'b0);
        act_beat("cqe_nl2", 64'h0000_0000_CAFE_F00D, 8'h02, 8'h0F, 1'b0, 1'b0);
        push_exp(64'h0000_0000_0000_0101, 8'h01, 8'hFF);
        act_beat("data_mm", 64'h0000_0000_0000_0202, 8'h01, 8'hFF, 1'b0, 1'b0);

        // Stats frames: EoT data masked, tstrb still compared
        do_reset();
        push_exp(64'h0000_0000_0000_0108, 8'h01, 8'hFF);
        push_exp(64'h0, 8'h02, 8'hFF);
        act_beat("st0", 64'h0000_0000_0000_0108, 8'h01, 8'hFF, 1'b0, 1'b0);
        act_beat("st1", 64'h0000_0000_DEAD_BEEF, 8'h02, 8'hFF, 1'b0, 1'b0);
        push_exp(64'h0000_0000_0000_0208, 8'h01, 8'hFF);
        push_exp(64'h0, 8'h02, 8'hFF);
        act_beat("st2", 64'h0000_0000_0000_0208, 8'h01, 8'hFF, 1'b0, 1'b0);
        act_beat("st3", 64'h0000_0000_DEAD_BEEF, 8'h02, 8'h0F, 1'b0, 1'b0);

        // Watchdog: one pending beat, no traffic
        do_reset();
        push_exp(64'h55, 8'h01, 8'hFF);
        repeat (WDOG - 1) @(posedge clk);
        #1;
        check_outputs("wdog_before");
        @(posedge clk);
        #1;
        m_wdog = 1;
        m_err  = 1;
        $display("wdog  expired=%0d err_count=%0d", wdog_expired, err_count);
        check_outputs("wdog_fire");
        repeat (30) @(posedge clk);
        #1;
        check_outputs("wdog_hold");

        // Beat with empty FIFO, then fill to full and free one slot
        do_reset();
        act_beat("no_exp", 64'h77, 8'h03, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(64'(i) + 64'h100, 8'h03, 8'hFF);
        end
        push_exp(64'hBAD, 8'h03, 8'hFF);
        check_val("full.exp_tready", 64'(exp_tready), 64'd0);
        act_beat("pop_full", 64'h100, 8'h03, 8'hFF, 1'b0, 1'b0);
        check_val("pop.exp_tready", 64'(exp_tready), 64'd1);

        // Clear has priority over same-cycle errors
        do_reset();
        push_exp(64'h0000_0000_0000_0301, 8'h01, 8'hFF);
        act_beat("three", 64'h0000_0000_0000_0999, 8'h03, 8'h0F, 1'b0, 1'b0);
        push_exp(64'h0000_0000_0000_1111, 8'h03, 8'hFF);
        act_beat("clr", 64'h0000_0000_0000_2222, 8'h03, 8'hFF, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
